// File: rtl/key_schedule.sv
// AES-128 key expansion: one round key per cycle into an 11-entry key store.
// Includes the 32-bit subByte S-box used for SubWord.

module subbyte (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = {SBOX[din[31:24]], SBOX[din[23:16]],
                 SBOX[din[15:8]],  SBOX[din[7:0]]};

endmodule

module key_schedule (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t       state;
  logic [3:0]   rnd;
  logic [127:0] rk [0:10];

  logic         accept;
  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [31:0]  temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_rk;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    unique case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign accept = key_valid & key_ready;

  // rnd is 0 only outside EXPAND; clamp so the read stays in range
  assign prev_idx = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;
  assign prev     = rk[prev_idx];
  assign rot      = {prev[23:0], prev[31:24]};

  subbyte u_sub (
    .din  (rot),
    .dout (sub)
  );

  assign temp    = sub ^ {rcon(rnd), 24'h0};
  assign n0      = prev[127:96] ^ temp;
  assign n1      = prev[95:64]  ^ n0;
  assign n2      = prev[63:32]  ^ n1;
  assign n3      = prev[31:0]   ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rnd        <= 4'd0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            state      <= EXPAND;
            rnd        <= 4'd1;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
          end
        end
        EXPAND: begin
          if (rnd == 4'd10) begin
            state      <= DONE;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: begin
          state      <= IDLE;
          rnd        <= 4'd0;
          key_ready  <= 1'b1;
          busy       <= 1'b0;
          keys_valid <= 1'b0;
        end
      endcase
    end
  end

  // Round-key store: rk0 on accept, rk[rnd] each EXPAND cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 11; i++) begin
        rk[i] <= '0;
      end
    end else if (accept) begin
      rk[0] <= key_in;
    end else if (state == EXPAND) begin
      rk[rnd] <= next_rk;
    end
  end

  // Combinational read port; out-of-range indices read as zero
  always_comb begin
    rd_key = '0;
    if (rd_idx <= 4'd10) begin
      rd_key = rk[rd_idx];
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule: FIPS-197 vectors, latency,
// ignored keys during expansion, back-to-back keys and reset cases.

module tb_key_schedule;

  logic         clk;
  logic         reset;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;

  vec_t         tbl [16];
  logic [127:0] sched_a [11];

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_schedule dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] idx, output logic [127:0] v);
    rd_idx = idx;
    #1;
    v = rd_key;
  endtask

  task automatic sweep(input string name);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) begin
      rd(tbl[i].idx, v);
      chk($sformatf("%s idx%0d", name, i), v, tbl[i].exp);
    end
  endtask

  task automatic all_zero(input string name);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      chk($sformatf("%s idx%0d", name, i), v, '0);
    end
  endtask

  // Accept k, optionally hammer key_valid with gk during EXPAND,
  // then measure edges until keys_valid and cycles with ready low.
  task automatic run_key(input logic [127:0] k,
                         input logic [127:0] gk,
                         input logic glitch,
                         input string name);
    int lat;
    int lowcnt;
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_in    = ~k;
    chk({name, " kv drop"}, 128'(keys_valid), 128'(0));
    chk({name, " busy"}, 128'(busy), 128'(1));
    lat    = 0;
    lowcnt = 0;
    while (!keys_valid && lat < 20) begin
      if (!key_ready && busy) lowcnt++;
      key_valid = glitch;
      key_in    = gk;
      @(posedge clk);
      #1;
      lat++;
    end
    key_valid = 1'b0;
    chk({name, " latency"}, 128'(lat), 128'(10));
    chk({name, " ready low"}, 128'(lowcnt), 128'(10));
    chk({name, " idle busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    logic [127:0] v;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rd_idx    = 4'd0;

    sched_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    sched_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    sched_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    sched_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    sched_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    sched_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    sched_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    sched_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    sched_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    sched_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    sched_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 16; i++) begin
      tbl[i].idx = 4'(i);
      tbl[i].exp = (i < 11) ? sched_a[i] : '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst key_ready", 128'(key_ready), 128'(1));
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst keys_valid", 128'(keys_valid), 128'(0));
    all_zero("rst rd_key");

    // FIPS-197 key from IDLE, full read sweep
    run_key(KEY_A, '0, 1'b0, "keyA");
    chk("keyA keys_valid", 128'(keys_valid), 128'(1));
    sweep("keyA sweep");

    // Back-to-back from DONE: all-zero key
    run_key('0, '0, 1'b0, "zero");
    rd(4'd0, v);
    chk("zero rk0", v, '0);
    rd(4'd1, v);
    chk("zero rk1", v, Z_RK1);
    rd(4'd10, v);
    chk("zero rk10", v, Z_RK10);

    // Key A with a different key offered throughout EXPAND
    run_key(KEY_A, 128'h00112233445566778899aabbccddeeff,
            1'b1, "glitch");
    sweep("glitch sweep");

    // Zero key ignoring key A offers, then key A aborted by reset
    run_key('0, KEY_A, 1'b1, "glitch0");
    rd(4'd10, v);
    chk("glitch0 rk10", v, Z_RK10);
    key_in    = KEY_A;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rd(4'd4, v);
    chk("mid rk4 written", v, sched_a[4]);
    chk("mid busy", 128'(busy), 128'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort key_ready", 128'(key_ready), 128'(1));
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort keys_valid", 128'(keys_valid), 128'(0));
    all_zero("abort rd_key");

    // Reset wins over a same-edge accept
    reset     = 1'b1;
    key_valid = 1'b1;
    key_in    = KEY_A;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    key_valid = 1'b0;
    chk("prio busy", 128'(busy), 128'(0));
    chk("prio key_ready", 128'(key_ready), 128'(1));
    rd(4'd0, v);
    chk("prio rk0", v, '0);
    repeat (12) @(posedge clk);
    #1;
    chk("prio keys_valid", 128'(keys_valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
